spi_arbiter: RTL and testbench

Shares one byte-wide SPI master among NUM_REQ requesters, each issuing multi-byte bursts over a per-byte valid/ready/last stream. Grants are round-robin and held for a whole burst, so a burst is never interleaved with another requester's bytes. The block sits between the requester logic and the SPI byte controller. It drives the controller's level-sensitive valid/data handshake and observes the controller's SS and ready outputs to sequence each byte.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_rr_picker.sv | 33 +++
 rtl/spi_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_spi_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI requester arbiter.
// The optional burst-abort timer is enabled with the SPI_ARB_TIMEOUT_EN macro.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        DRAIN,
        NEXT
    } spi_arb_state_t;

    // Width of a requester index; at least one bit so a single requester still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: searches upward from the requester after the last grant
// and returns the first active request as a one-hot vector and as an index.
module spi_rr_picker
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    // Walk the candidates last+1 .. last+NUM_REQ (mod NUM_REQ) and keep the first hit.
    always_comb begin
        int cand;
        cand       = 0;
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_idx) + k) % NUM_REQ;
            if (!win_valid && req_vec[cand]) begin
                win_valid        = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI master among NUM_REQ requesters.
// A grant is held for a whole burst so bytes of different requesters never interleave.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a burst whose owner stays silent
// for TIMEOUT_CYCLES cycles between bytes; without it timeoutOut is tied low.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          sysClkIn,
    input  logic                          sysRstIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    input  logic [NUM_REQ*SPI_BYTE_W-1:0] reqDataIn,
    input  logic [NUM_REQ-1:0]            reqLastIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    output logic [NUM_REQ-1:0]            grantOut,
    output logic                          busyOut,
    output logic                          timeoutOut,
    output logic                          spiValidOut,
    output logic [SPI_BYTE_W-1:0]         spiDataOut,
    input  logic                          spiReadyIn,
    input  logic                          spiSsIn
);

    localparam int IDX_W = idx_width(NUM_REQ);

    spi_arb_state_t        state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [SPI_BYTE_W-1:0] data_q, data_d;
    logic                  last_q, last_d;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    logic [IDX_W-1:0]      sel_idx;
    logic [SPI_BYTE_W-1:0] sel_data;
    logic                  sel_last;
    logic                  capture;
    logic [NUM_REQ-1:0]    ready_mask;
    logic                  spi_valid;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    // The timer is absent in this build; the parameter is kept so both builds share one port list.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
    end
`endif

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_vec    (reqValidIn),
        .last_idx   (last_grant_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    // Source of the byte being captured: the fresh winner in IDLE, the burst owner otherwise.
    always_comb begin
        sel_idx  = (state_q == IDLE) ? pick_idx : last_grant_q;
        sel_data = reqDataIn[int'(sel_idx)*SPI_BYTE_W +: SPI_BYTE_W];
        sel_last = reqLastIn[sel_idx];
    end

    // Next-state, grant bookkeeping and handshake outputs of the burst FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        last_d       = last_q;
        capture      = 1'b0;
        ready_mask   = '0;
        spi_valid    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (spiReadyIn && pick_valid) begin
                    capture      = 1'b1;
                    ready_mask   = pick_onehot;
                    grant_d      = pick_onehot;
                    last_grant_d = pick_idx;
                    state_d      = START;
                end
            end
            START: begin
                spi_valid = 1'b1;
                if (!spiSsIn) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                spi_valid = 1'b1;
                if (spiSsIn) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (spiReadyIn) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (reqValidIn[last_grant_q] && spiReadyIn) begin
                    capture    = 1'b1;
                    ready_mask = grant_q;
                    state_d    = START;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            data_d = sel_data;
            last_d = sel_last;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d  = '0;
`endif
        end

        // A capture during reset would be lost, so never strobe a requester then.
        if (sysRstIn) begin
            ready_mask = '0;
        end
    end

    // Burst state register; reset drops any in-flight byte and returns priority to requester 0.
    always_ff @(posedge sysClkIn) begin
        if (sysRstIn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            data_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            last_q       <= last_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Inter-byte silence counter and the registered abort pulse.
    always_ff @(posedge sysClkIn) begin
        if (sysRstIn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeoutOut = timeout_q;
`else
    assign timeoutOut = 1'b0;
`endif

    assign reqReadyOut = ready_mask;
    assign grantOut    = grant_q;
    assign busyOut     = |grant_q;
    assign spiValidOut = spi_valid;
    assign spiDataOut  = data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: requester queues feed bursts, a small SPI controller
// model returns SS/ready, and every byte it shifts out is matched against a scoreboard.
// The abort scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           sysRstIn = 1'b1;
    logic [N-1:0]   reqValidIn = '0;
    logic [N*8-1:0] reqDataIn = '0;
    logic [N-1:0]   reqLastIn = '0;
    logic [N-1:0]   reqReadyOut;
    logic [N-1:0]   grantOut;
    logic           busyOut;
    logic           timeoutOut;
    logic           spiValidOut;
    logic [7:0]     spiDataOut;
    logic           spiReadyIn = 1'b1;
    logic           spiSsIn = 1'b1;

    int assert_count = 0;
    int fail_count = 0;

    logic [8:0]  req_q [N][$];
    logic [11:0] mosi_q[$];
    logic [11:0] exp_q[$];
    logic [N-1:0] acc = '0;
    int ready_count [N];
    int multi_ready = 0;
    int timeout_pulses = 0;
    int ctrl_state = 0;
    int shift_cnt = 0;

    spi_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sysClkIn    (clk),
        .sysRstIn    (sysRstIn),
        .reqValidIn  (reqValidIn),
        .reqDataIn   (reqDataIn),
        .reqLastIn   (reqLastIn),
        .reqReadyOut (reqReadyOut),
        .grantOut    (grantOut),
        .busyOut     (busyOut),
        .timeoutOut  (timeoutOut),
        .spiValidOut (spiValidOut),
        .spiDataOut  (spiDataOut),
        .spiReadyIn  (spiReadyIn),
        .spiSsIn     (spiSsIn)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: records accept strobes and abort pulses.
    always @(negedge clk) begin
        acc = reqReadyOut;
        for (int i = 0; i < N; i++) begin
            if (reqReadyOut[i]) ready_count[i]++;
        end
        if ($countones(reqReadyOut) > 1) multi_ready++;
        if (timeoutOut) timeout_pulses++;
    end

    // Requester model: drops accepted bytes and presents the head of each queue.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        end
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (req_q[i].size() > 0) begin
                {reqLastIn[i], reqDataIn[i*8 +: 8]} = req_q[i][0];
                reqValidIn[i] = 1'b1;
            end else begin
                reqLastIn[i]        = 1'b0;
                reqDataIn[i*8 +: 8] = 8'h00;
                reqValidIn[i]       = 1'b0;
            end
        end
    end

    // SPI byte controller model: SS low for a few cycles per byte, ready once valid drops.
    always @(negedge clk) begin
        if (sysRstIn) begin
            ctrl_state = 0;
            spiSsIn    = 1'b1;
            spiReadyIn = 1'b1;
        end else begin
            case (ctrl_state)
                0: if (spiValidOut) begin
                    mosi_q.push_back({grantOut, spiDataOut});
                    spiSsIn    = 1'b0;
                    spiReadyIn = 1'b0;
                    shift_cnt  = 4;
                    ctrl_state = 1;
                end
                1: begin
                    shift_cnt--;
                    if (shift_cnt == 0) begin
                        spiSsIn    = 1'b1;
                        ctrl_state = 2;
                    end
                end
                default: if (!spiValidOut) begin
                    spiReadyIn = 1'b1;
                    ctrl_state = 0;
                end
            endcase
        end
    end

    task automatic push_req(input int r, input logic [7:0] d, input logic last);
        req_q[r].push_back({last, d});
        exp_q.push_back({4'(1 << r), d});
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) ready_count[i] = 0;
        multi_ready    = 0;
        timeout_pulses = 0;
        mosi_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int quiet;
        bit empty;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (req_q[i].size() != 0) empty = 1'b0;
            if (empty && grantOut == '0 && !spiValidOut) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        assert_count++;
        if (reqReadyOut !== 4'b0000) begin fail_count++; $display("[TB] FAIL rst_ready: got %b want 0000", reqReadyOut); end
        assert_count++;
        if (grantOut !== 4'b0000) begin fail_count++; $display("[TB] FAIL rst_grant: got %b want 0000", grantOut); end
        assert_count++;
        if (busyOut !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_busy: got %b want 0", busyOut); end
        assert_count++;
        if (timeoutOut !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_timeout: got %b want 0", timeoutOut); end
        assert_count++;
        if (spiValidOut !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_valid: got %b want 0", spiValidOut); end
        assert_count++;
        if (spiDataOut !== 8'h00) begin fail_count++; $display("[TB] FAIL rst_data: got %h want 00", spiDataOut); end
        sysRstIn = 1'b0;
        $display("[TB] reset checks done");
    endtask

    task automatic test_single_burst();
        bit seen;
        bit ok;
        logic [11:0] e;
        logic [11:0] g;
        clear_counts();
        @(posedge clk);
        #1;
        push_req(0, 8'hA5, 1'b0);
        push_req(0, 8'h3C, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (reqReadyOut[0]) begin seen = 1'b1; break; end
        end
        assert_count++;
        if (!seen) begin fail_count++; $display("[TB] FAIL single_accept: got no strobe want reqReadyOut[0]"); end
        @(posedge clk);
        #1;
        assert_count++;
        if (spiValidOut !== 1'b1) begin fail_count++; $display("[TB] FAIL single_valid_t1: got %b want 1", spiValidOut); end
        assert_count++;
        if (grantOut !== 4'b0001) begin fail_count++; $display("[TB] FAIL single_grant: got %b want 0001", grantOut); end
        assert_count++;
        if (busyOut !== 1'b1) begin fail_count++; $display("[TB] FAIL single_busy: got %b want 1", busyOut); end
        assert_count++;
        if (reqReadyOut !== 4'b0000) begin fail_count++; $display("[TB] FAIL single_ready_pulse: got %b want 0000", reqReadyOut); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!spiValidOut) break;
            assert_count++;
            if (spiDataOut !== 8'hA5) begin fail_count++; $display("[TB] FAIL single_data_hold: got %h want a5 (reqData0=%h)", spiDataOut, reqDataIn[7:0]); end
        end
        wait_done(400, ok);
        assert_count++;
        if (!ok) begin fail_count++; $display("[TB] FAIL single_done: got busy/pending want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert_count++;
            if (mosi_q.size() == 0) begin
                fail_count++; $display("[TB] FAIL single_byte: got nothing want grant=%b data=%h", e[11:8], e[7:0]);
            end else begin
                g = mosi_q.pop_front();
                if (g !== e) begin fail_count++; $display("[TB] FAIL single_byte: got grant=%b data=%h want grant=%b data=%h", g[11:8], g[7:0], e[11:8], e[7:0]); end
            end
        end
        assert_count++;
        if (ready_count[0] != 2) begin fail_count++; $display("[TB] FAIL single_ready_count: got %0d want 2", ready_count[0]); end
        assert_count++;
        if (mosi_q.size() != 0) begin fail_count++; $display("[TB] FAIL single_extra: got %0d extra bytes want 0", mosi_q.size()); end
        assert_count++;
        if (busyOut !== 1'b0) begin fail_count++; $display("[TB] FAIL single_busy_end: got %b want 0", busyOut); end
        $display("[TB] single burst done");
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [11:0] e;
        logic [11:0] g;
        @(posedge clk);
        #1;
        sysRstIn = 1'b1;
        @(posedge clk);
        #1;
        sysRstIn = 1'b0;
        clear_counts();
        push_req(1, 8'h11, 1'b0);
        push_req(1, 8'h12, 1'b1);
        push_req(1, 8'h13, 1'b1);
        push_req(2, 8'h21, 1'b1);
        // Requester 2 must be served between requester 1's two bursts.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        exp_q.push_back({4'b0100, 8'h21});
        exp_q.push_back({4'b0010, 8'h13});
        wait_done(600, ok);
        assert_count++;
        if (!ok) begin fail_count++; $display("[TB] FAIL rr_done: got busy/pending want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert_count++;
            if (mosi_q.size() == 0) begin
                fail_count++; $display("[TB] FAIL rr_byte: got nothing want grant=%b data=%h", e[11:8], e[7:0]);
            end else begin
                g = mosi_q.pop_front();
                if (g !== e) begin fail_count++; $display("[TB] FAIL rr_byte: got grant=%b data=%h want grant=%b data=%h", g[11:8], g[7:0], e[11:8], e[7:0]); end
            end
        end
        assert_count++;
        if (multi_ready != 0) begin fail_count++; $display("[TB] FAIL rr_onehot: got %0d multi-strobe cycles want 0", multi_ready); end
        $display("[TB] round robin done");
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen;
        logic [11:0] e;
        logic [11:0] g;
        clear_counts();
        @(posedge clk);
        #1;
        push_req(0, 8'h01, 1'b0);
        push_req(0, 8'h02, 1'b0);
        push_req(0, 8'h03, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (grantOut == 4'b0001) begin seen = 1'b1; break; end
        end
        assert_count++;
        if (!seen) begin fail_count++; $display("[TB] FAIL b2b_grant0: got %b want 0001", grantOut); end
        @(posedge clk);
        #1;
        push_req(3, 8'h31, 1'b1);
        wait_done(600, ok);
        assert_count++;
        if (!ok) begin fail_count++; $display("[TB] FAIL b2b_done: got busy/pending want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert_count++;
            if (mosi_q.size() == 0) begin
                fail_count++; $display("[TB] FAIL b2b_byte: got nothing want grant=%b data=%h", e[11:8], e[7:0]);
            end else begin
                g = mosi_q.pop_front();
                if (g !== e) begin fail_count++; $display("[TB] FAIL b2b_byte: got grant=%b data=%h want grant=%b data=%h", g[11:8], g[7:0], e[11:8], e[7:0]); end
            end
        end
        assert_count++;
        if (ready_count[0] != 3 || ready_count[3] != 1) begin
            fail_count++; $display("[TB] FAIL b2b_ready_count: got r0=%0d r3=%0d want r0=3 r3=1", ready_count[0], ready_count[3]);
        end
        $display("[TB] back to back done");
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bit seen;
        logic [11:0] e;
        logic [11:0] g;
        clear_counts();
        @(posedge clk);
        #1;
        push_req(0, 8'h77, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (spiValidOut && !spiSsIn) begin seen = 1'b1; break; end
        end
        assert_count++;
        if (!seen) begin fail_count++; $display("[TB] FAIL rstmid_xfer: got no transfer want SS low"); end
        @(posedge clk);
        #1;
        sysRstIn = 1'b1;
        @(posedge clk);
        #1;
        assert_count++;
        if (spiValidOut !== 1'b0) begin fail_count++; $display("[TB] FAIL rstmid_valid: got %b want 0", spiValidOut); end
        assert_count++;
        if (grantOut !== 4'b0000) begin fail_count++; $display("[TB] FAIL rstmid_grant: got %b want 0000", grantOut); end
        sysRstIn = 1'b0;
        push_req(1, 8'h66, 1'b1);
        push_req(0, 8'h55, 1'b1);
        // Requester 0 has first priority after reset, whatever order the requests were queued.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        exp_q.push_back({4'b0001, 8'h55});
        exp_q.push_back({4'b0010, 8'h66});
        wait_done(600, ok);
        assert_count++;
        if (!ok) begin fail_count++; $display("[TB] FAIL rstmid_done: got busy/pending want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert_count++;
            if (mosi_q.size() == 0) begin
                fail_count++; $display("[TB] FAIL rstmid_byte: got nothing want grant=%b data=%h", e[11:8], e[7:0]);
            end else begin
                g = mosi_q.pop_front();
                if (g !== e) begin fail_count++; $display("[TB] FAIL rstmid_byte: got grant=%b data=%h want grant=%b data=%h", g[11:8], g[7:0], e[11:8], e[7:0]); end
            end
        end
        $display("[TB] reset mid burst done");
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit seen;
        int gap;
        logic [11:0] e;
        logic [11:0] g;
        clear_counts();
        @(posedge clk);
        #1;
        push_req(2, 8'h2A, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (spiValidOut) begin seen = 1'b1; break; end
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!spiValidOut) break;
        end
        gap = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (timeoutOut) begin gap = c; break; end
        end
        assert_count++;
        if (!seen || gap != 17) begin fail_count++; $display("[TB] FAIL to_gap: got %0d cycles after drain want 17", gap); end
        @(posedge clk);
        #1;
        push_req(1, 8'h1B, 1'b1);
        push_req(3, 8'h3B, 1'b1);
        // The search restarts after the aborted requester 2, so 3 precedes 1.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        exp_q.push_back({4'b1000, 8'h3B});
        exp_q.push_back({4'b0010, 8'h1B});
        wait_done(600, ok);
        assert_count++;
        if (!ok) begin fail_count++; $display("[TB] FAIL to_done: got busy/pending want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert_count++;
            if (mosi_q.size() == 0) begin
                fail_count++; $display("[TB] FAIL to_byte: got nothing want grant=%b data=%h", e[11:8], e[7:0]);
            end else begin
                g = mosi_q.pop_front();
                if (g !== e) begin fail_count++; $display("[TB] FAIL to_byte: got grant=%b data=%h want grant=%b data=%h", g[11:8], g[7:0], e[11:8], e[7:0]); end
            end
        end
        assert_count++;
        if (timeout_pulses != 1) begin fail_count++; $display("[TB] FAIL to_pulses: got %0d want 1", timeout_pulses); end
        $display("[TB] timeout done");
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion want finish before 300us");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
